// File: rtl/pq_arb.sv
`default_nettype none
// ============================================================================
// Module      : pq_arb
// Description : Round-robin arbiter that serialises enqueue/dequeue requests
//               from NREQ requesters onto a single priority-queue port.
//               One PQ operation is outstanding at a time; each served
//               requester receives a one-cycle ack with response data/error.
// Revision    : 1.0 - initial release
// ============================================================================
module pq_arb #(
    parameter int NREQ = 4,
    parameter int KVW  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_enq,
    input  logic [NREQ-1:0]     req_deq,
    input  logic [NREQ*KVW-1:0] req_kv,
    output logic [NREQ-1:0]     ack,
    output logic [KVW-1:0]      rsp_kv,
    output logic                rsp_err,
    output logic                pq_enq,
    output logic                pq_deq,
    output logic [KVW-1:0]      pq_kvi,
    input  logic [KVW-1:0]      pq_kvo,
    input  logic                pq_busy,
    input  logic                pq_full,
    input  logic                pq_empty
);

    localparam int c_SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [c_SELW-1:0] r_ptr;
    logic [c_SELW-1:0] r_sel;
    logic [c_SELW-1:0] w_pick;
    logic              r_enq;      // captured op: 1 = enqueue, 0 = dequeue
    logic              r_bad;      // requester raised enq and deq together
    logic              r_err;
    logic [KVW-1:0]    r_kv;       // captured enqueue data
    logic [KVW-1:0]    r_cap;      // last dequeued word, drives rsp_kv
    logic [NREQ-1:0]   w_pend;
    logic              w_any;
    logic              w_reject;
    logic              w_fire;
    logic [KVW-1:0]    w_kv_arr [NREQ];

    assign w_pend = req_enq | req_deq;

    // Split the flat request data bus into one word per requester
    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_split
            assign w_kv_arr[g] = req_kv[g*KVW +: KVW];
        end
    endgenerate

    // Round-robin pick: scan from ptr+1 upward with wrap, first pending wins
    always_comb begin
        int j;
        logic [c_SELW-1:0] j_sel;
        w_any  = 1'b0;
        w_pick = '0;
        j      = 0;
        j_sel  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            j_sel = j[c_SELW-1:0];
            if (!w_any && w_pend[j_sel]) begin
                w_any  = 1'b1;
                w_pick = j_sel;
            end
        end
    end

    // An operation is refused when malformed, or when the queue cannot take it.
    // Full/empty is only trusted once the queue is idle.
    assign w_reject = r_bad | (~pq_busy & (r_enq ? pq_full : pq_empty));
    assign w_fire   = (r_state == c_ISSUE) & ~w_reject & ~pq_busy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_next = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (w_reject) begin
                    w_next = c_RESP;
                end else if (!pq_busy) begin
                    w_next = c_WAIT;
                end
            end
            c_WAIT: begin
                if (!pq_busy) begin
                    w_next = c_RESP;
                end
            end
            c_RESP: begin
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // Output decode: PQ strobes in ISSUE, requester response in RESP
    always_comb begin
        pq_enq  = 1'b0;
        pq_deq  = 1'b0;
        pq_kvi  = '0;
        ack     = '0;
        rsp_err = 1'b0;
        if (w_fire) begin
            if (r_enq) begin
                pq_enq = 1'b1;
                pq_kvi = r_kv;
            end else begin
                pq_deq = 1'b1;
            end
        end
        if (r_state == c_RESP) begin
            ack[r_sel] = 1'b1;
            rsp_err    = r_err;
        end
    end

    // The captured word only changes on the edge into RESP, so it is valid in
    // the ack cycle and holds its value everywhere else.
    assign rsp_kv = r_cap;

    // Datapath: capture the granted request, track errors, result and pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= c_SELW'(NREQ - 1);
            r_sel <= '0;
            r_enq <= 1'b0;
            r_bad <= 1'b0;
            r_err <= 1'b0;
            r_kv  <= '0;
            r_cap <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_sel <= w_pick;
                        r_enq <= req_enq[w_pick];
                        r_bad <= req_enq[w_pick] & req_deq[w_pick];
                        r_kv  <= w_kv_arr[w_pick];
                        r_err <= 1'b0;
                    end
                end
                c_ISSUE: begin
                    if (w_reject) begin
                        r_err <= 1'b1;
                    end
                end
                c_WAIT: begin
                    if (!pq_busy && !r_enq) begin
                        r_cap <= pq_kvo;
                    end
                end
                c_RESP: begin
                    r_ptr <= r_sel;
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pq_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pq_arb
// Description : Directed self-checking bench for pq_arb with a small
//               behavioural min-priority-queue (depth 8) on the PQ port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pq_arb;

    localparam int NREQ = 4;
    localparam int KVW  = 16;
    localparam int c_DEPTH = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_enq = '0;
    logic [NREQ-1:0]     req_deq = '0;
    logic [NREQ*KVW-1:0] req_kv  = '0;
    logic [NREQ-1:0]     ack;
    logic [KVW-1:0]      rsp_kv;
    logic                rsp_err;
    logic                pq_enq;
    logic                pq_deq;
    logic [KVW-1:0]      pq_kvi;
    logic [KVW-1:0]      pq_kvo = '0;
    logic                pq_busy;
    logic                pq_full;
    logic                pq_empty;

    int tests = 0;
    int fails = 0;

    pq_arb #(.NREQ(NREQ), .KVW(KVW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_enq  (req_enq),
        .req_deq  (req_deq),
        .req_kv   (req_kv),
        .ack      (ack),
        .rsp_kv   (rsp_kv),
        .rsp_err  (rsp_err),
        .pq_enq   (pq_enq),
        .pq_deq   (pq_deq),
        .pq_kvi   (pq_kvi),
        .pq_kvo   (pq_kvo),
        .pq_busy  (pq_busy),
        .pq_full  (pq_full),
        .pq_empty (pq_empty)
    );

    always #5 clk = ~clk;

    // Behavioural min-queue: each strobe makes it busy for two cycles
    logic [KVW-1:0] q [$];
    int             qn = 0;
    int             busy_cnt = 0;
    logic           busy_force = 1'b0;

    assign pq_busy  = busy_force | (busy_cnt != 0);
    assign pq_full  = (qn >= c_DEPTH);
    assign pq_empty = (qn == 0);

    // Queue model update
    always @(posedge clk) begin : m_pq
        int mi;
        mi = 0;
        if (pq_enq) begin
            q.push_back(pq_kvi);
            qn       <= qn + 1;
            busy_cnt <= 2;
        end else if (pq_deq) begin
            if (q.size() > 0) begin
                for (int i = 1; i < q.size(); i++) begin
                    if (q[i] < q[mi]) mi = i;
                end
                pq_kvo <= q[mi];
                q.delete(mi);
                qn <= qn - 1;
            end
            busy_cnt <= 2;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Strobe / ack observers
    int             enq_seen = 0;
    int             deq_seen = 0;
    int             ack_seen = 0;
    logic [KVW-1:0] last_kvi = '0;

    always @(posedge clk) begin
        if (pq_enq) begin
            enq_seen <= enq_seen + 1;
            last_kvi <= pq_kvi;
        end
        if (pq_deq) deq_seen <= deq_seen + 1;
        if (ack != 0) ack_seen <= ack_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance negedge by negedge until an ack appears (bounded)
    task automatic wait_ack(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ack != 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check({tag, "_ack_timeout"}, 32'(ok), 32'd1);
    endtask

    // One single-requester transaction with expected response and strobe counts
    task automatic do_op(input string tag, input int r, input bit e, input bit d,
                         input logic [KVW-1:0] kv, input bit exp_err,
                         input int exp_enq, input int exp_deq,
                         input bit chk_kv, input logic [KVW-1:0] exp_kv);
        int e0, d0;
        e0 = enq_seen;
        d0 = deq_seen;
        @(negedge clk);
        req_enq[r] = e;
        req_deq[r] = d;
        req_kv[r*KVW +: KVW] = kv;
        @(negedge clk);
        wait_ack(tag);
        check({tag, "_ack"}, 32'(ack), 32'(1) << r);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_nenq"}, 32'(enq_seen - e0), 32'(exp_enq));
        check({tag, "_ndeq"}, 32'(deq_seen - d0), 32'(exp_deq));
        if (chk_kv) check({tag, "_kv"}, 32'(rsp_kv), 32'(exp_kv));
        req_enq[r] = 1'b0;
        req_deq[r] = 1'b0;
        @(negedge clk);
        check({tag, "_ack_clr"}, 32'(ack), 32'd0);
        if (chk_kv) check({tag, "_kv_hold"}, 32'(rsp_kv), 32'(exp_kv));
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        int e0, d0, a0;
        bit ok;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_kv", 32'(rsp_kv), 32'd0);
        check("rst_strobes", {30'd0, pq_enq, pq_deq}, 32'd0);
        check("rst_kvi", 32'(pq_kvi), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Dequeue from an empty queue is refused without a strobe
        do_op("deq_empty", 1, 1'b0, 1'b1, 16'h0000, 1'b1, 0, 0, 1'b0, 16'h0000);

        // Single enqueue from requester 2
        do_op("enq_r2", 2, 1'b1, 1'b0, 16'h0042, 1'b0, 1, 0, 1'b0, 16'h0000);
        check("enq_r2_kvi", 32'(last_kvi), 32'h0042);

        // Min-queue ordering seen through the arbiter
        do_op("enq_5", 0, 1'b1, 1'b0, 16'h0005, 1'b0, 1, 0, 1'b0, 16'h0000);
        do_op("enq_3", 1, 1'b1, 1'b0, 16'h0003, 1'b0, 1, 0, 1'b0, 16'h0000);
        do_op("deq_min", 3, 1'b0, 1'b1, 16'h0000, 1'b0, 0, 1, 1'b1, 16'h0003);

        // Enqueue and dequeue raised together: rejected, no strobe
        do_op("both", 0, 1'b1, 1'b1, 16'h00AA, 1'b1, 0, 0, 1'b0, 16'h0000);

        // Busy held for several cycles during ISSUE
        e0 = enq_seen;
        @(negedge clk);
        busy_force = 1'b1;
        req_enq[3] = 1'b1;
        req_kv[3*KVW +: KVW] = 16'h0007;
        repeat (6) @(negedge clk);
        check("busy_nostrobe", 32'(enq_seen - e0), 32'd0);
        check("busy_noack", 32'(ack), 32'd0);
        busy_force = 1'b0;
        wait_ack("busy");
        check("busy_ack", 32'(ack), 32'b1000);
        check("busy_err", 32'(rsp_err), 32'd0);
        check("busy_nenq", 32'(enq_seen - e0), 32'd1);
        check("busy_kvi", 32'(last_kvi), 32'h0007);
        req_enq[3] = 1'b0;
        @(negedge clk);

        // All four requesters enqueue continuously: order 0,1,2,3,0
        e0 = enq_seen;
        req_enq = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_kv[i*KVW +: KVW] = 16'(16'h0010 + i);
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            wait_ack("rr");
            check($sformatf("rr_grant%0d", n), 32'(ack), 32'(1) << exp_order[n]);
            check($sformatf("rr_err%0d", n), 32'(rsp_err), 32'd0);
            if (n < 4) @(negedge clk);
        end
        req_enq = '0;
        @(negedge clk);
        check("rr_nenq", 32'(enq_seen - e0), 32'd5);

        // Queue now full: enqueue refused
        do_op("enq_full", 1, 1'b1, 1'b0, 16'h0099, 1'b1, 0, 0, 1'b0, 16'h0000);

        // Reset while waiting on the queue abandons the operation
        d0 = deq_seen;
        @(negedge clk);
        req_deq[2] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (deq_seen != d0) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstw_strobe", 32'(ok), 32'd1);
        a0 = ack_seen;
        rst = 1'b1;
        #1;
        check("rstw_ack", 32'(ack), 32'd0);
        check("rstw_err", 32'(rsp_err), 32'd0);
        check("rstw_kv", 32'(rsp_kv), 32'd0);
        check("rstw_strobes", {30'd0, pq_enq, pq_deq}, 32'd0);
        check("rstw_kvi", 32'(pq_kvi), 32'd0);
        req_deq = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstw_noack", 32'(ack_seen - a0), 32'd0);

        // Arbitration restarts at requester 0
        req_deq = 4'b1111;
        @(negedge clk);
        wait_ack("post_rst");
        check("post_rst_ack", 32'(ack), 32'b0001);
        check("post_rst_err", 32'(rsp_err), 32'd0);
        check("post_rst_kv", 32'(rsp_kv), 32'h0007);
        req_deq = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
